// File: rtl/rriot_bus_seq_if.sv
// CPU-side 6502 bus pins of the RRIOT timer sequencer.
// master = CPU, slave = sequencer.
interface rriot_bus_seq_if;
    logic       phi2;
    logic       cs;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_oe;
    logic       irq_n_pin;

    modport master (
        output phi2, cs, rw, addr, din,
        input  dout, dout_oe, irq_n_pin
    );

    modport slave (
        input  phi2, cs, rw, addr, din,
        output dout, dout_oe, irq_n_pin
    );
endinterface

// File: rtl/rriot_bus_seq.sv
// Turns asynchronous phi2/CS bus cycles into one clk-domain timer
// access per selected cycle, with read-back and IRQ pin drive.
module rriot_bus_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rriot_bus_seq_if.slave        bus,
    output logic [7:0]            abort_cnt,
    output logic                  tmr_we_n,
    output logic [2:0]            tmr_a,
    output logic [7:0]            tmr_di,
    input  logic [7:0]            tmr_do,
    input  logic                  tmr_irq_n
);

    typedef enum logic [2:0] {
        IDLE, SETUP, WRITE, READ, CAPT, HOLD, ABORT
    } state_t;

    localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] A_IDLE = 3'b001;

    logic [SYNC_STAGES-1:0] phi2_sync_q, phi2_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] vld_sync_q, vld_sync_d;
    logic       phi2_dly_q, phi2_dly_d;
    logic       armed_q, armed_d;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_oe_q, dout_oe_d;
    logic       irq_q, irq_d;
    logic [7:0] abort_q, abort_d;
    logic       we_n_q, we_n_d;
    logic [2:0] tmr_a_q, tmr_a_d;
    logic [7:0] tmr_di_q, tmr_di_d;

    logic phi2_s, cs_s, vld_s, rise;

    assign phi2_s = phi2_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign vld_s  = vld_sync_q[SYNC_STAGES-1];
    // armed only after phi2 was genuinely seen low, so a phi2
    // still high across reset release is not taken as a rise
    assign rise   = phi2_s & ~phi2_dly_q & armed_q;

    always_comb begin
        phi2_sync_d = {phi2_sync_q[SYNC_STAGES-2:0], bus.phi2};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
        vld_sync_d  = {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
        phi2_dly_d  = phi2_s;
        armed_d     = armed_q | (vld_s & ~phi2_s);
        irq_d       = tmr_irq_n;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        dout_d      = dout_q;
        dout_oe_d   = dout_oe_q;
        abort_d     = abort_q;
        tmr_a_d     = tmr_a_q;
        tmr_di_d    = tmr_di_q;

        unique case (state_q)
            IDLE: begin
                if (rise && cs_s) begin
                    rw_d    = bus.rw;
                    tmr_a_d = bus.addr;
                    cnt_d   = 4'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!phi2_s) begin
                    state_d = ABORT;
                end else if (cnt_q == LAST) begin
                    state_d = rw_q ? READ : WRITE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WRITE: state_d = HOLD;
            READ:  state_d = CAPT;
            CAPT: begin
                dout_d    = tmr_do;
                dout_oe_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (!phi2_s) begin
                    dout_oe_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            ABORT: begin
                if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        we_n_d = (state_d != WRITE);
        if (state_d == WRITE) tmr_di_d = bus.din;
        if (state_d == IDLE)  tmr_a_d  = A_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi2_sync_q <= '0;
            cs_sync_q   <= '0;
            vld_sync_q  <= '0;
            phi2_dly_q  <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rw_q        <= 1'b1;
            dout_q      <= 8'h00;
            dout_oe_q   <= 1'b0;
            irq_q       <= 1'b1;
            abort_q     <= 8'h00;
            we_n_q      <= 1'b1;
            tmr_a_q     <= A_IDLE;
            tmr_di_q    <= 8'h00;
        end else begin
            phi2_sync_q <= phi2_sync_d;
            cs_sync_q   <= cs_sync_d;
            vld_sync_q  <= vld_sync_d;
            phi2_dly_q  <= phi2_dly_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            dout_q      <= dout_d;
            dout_oe_q   <= dout_oe_d;
            irq_q       <= irq_d;
            abort_q     <= abort_d;
            we_n_q      <= we_n_d;
            tmr_a_q     <= tmr_a_d;
            tmr_di_q    <= tmr_di_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_oe   = dout_oe_q;
    assign bus.irq_n_pin = irq_q;
    assign abort_cnt     = abort_q;
    assign tmr_we_n      = we_n_q;
    assign tmr_a         = tmr_a_q;
    assign tmr_di        = tmr_di_q;

endmodule

// File: tb/tb_rriot_bus_seq.sv
// Bench for rriot_bus_seq: scoreboarded timer strobes and reads,
// table of bus cycles, plus latency, reset, IRQ and abort sequences.
module tb_rriot_bus_seq;

    localparam int LAT_WR = 5;
    localparam int LAT_RD = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tmr_irq_n = 1'b1;

    logic [7:0] abort_a, abort_b;
    logic       we_n_a, we_n_b;
    logic [2:0] ta_a, ta_b;
    logic [7:0] tdi_a, tdi_b;
    logic [7:0] tdo_a;
    logic [7:0] tdo_b = 8'h00;

    rriot_bus_seq_if bus_a ();
    rriot_bus_seq_if bus_b ();

    rriot_bus_seq #(.SYNC_STAGES(2), .SETTLE_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .abort_cnt(abort_a), .tmr_we_n(we_n_a), .tmr_a(ta_a),
        .tmr_di(tdi_a), .tmr_do(tdo_a), .tmr_irq_n(tmr_irq_n)
    );

    rriot_bus_seq #(.SYNC_STAGES(2), .SETTLE_CYC(4)) u_short (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .abort_cnt(abort_b), .tmr_we_n(we_n_b), .tmr_a(ta_b),
        .tmr_di(tdi_b), .tmr_do(tdo_b), .tmr_irq_n(tmr_irq_n)
    );

    always #5 clk = ~clk;

    // registered timer register file
    logic [7:0] regs [8];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'hC0 | 8'(i);
            regs[4] <= 8'h3F;
            tdo_a <= 8'h00;
        end else begin
            if (!we_n_a) regs[ta_a] <= tdi_a;
            tdo_a <= regs[ta_a];
        end
    end

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [10:0] wq[$];
    logic [7:0]  rq[$];
    logic oe_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!we_n_a) begin
                wr_cnt++;
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected act=%0h exp=none",
                             {ta_a, tdi_a});
                end else begin
                    chk("wr_strobe", {ta_a, tdi_a}, wq.pop_front());
                end
            end
            if (bus_a.dout_oe && !oe_prev) begin
                rd_cnt++;
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected act=%0h exp=none",
                             bus_a.dout);
                end else begin
                    chk("rd_data", bus_a.dout, rq.pop_front());
                end
            end
        end
        oe_prev = bus_a.dout_oe;
    end

    task automatic drive(input logic p, input logic c, input logic r,
                         input logic [2:0] a, input logic [7:0] d);
        bus_a.phi2 = p; bus_a.cs = c; bus_a.rw = r;
        bus_a.addr = a; bus_a.din = d;
        bus_b.phi2 = p; bus_b.cs = c; bus_b.rw = r;
        bus_b.addr = a; bus_b.din = d;
    endtask

    task automatic phi2_set(input logic p);
        bus_a.phi2 = p;
        bus_b.phi2 = p;
    endtask

    task automatic bus_cycle(input logic c, input logic r,
                             input logic [2:0] a, input logic [7:0] d,
                             input int hi, input int lo);
        @(negedge clk);
        drive(1'b1, c, r, a, d);
        repeat (hi) @(negedge clk);
        phi2_set(1'b0);
        repeat (lo) @(negedge clk);
    endtask

    typedef struct {
        logic       cs;
        logic       rw;
        logic [2:0] addr;
        logic [7:0] din;
        int         hi;
        int         exp_wr;
        int         exp_rd;
        logic [7:0] exp_do;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, kf, w0, r0;
        logic oe_seen;

        tbl[0] = '{1'b1, 1'b0, 3'd2, 8'hA5, 20,  1, 0, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 3'd2, 8'h00, 20,  0, 1, 8'hA5};
        tbl[2] = '{1'b1, 1'b0, 3'd7, 8'hFF, 20,  1, 0, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 3'd7, 8'h00, 20,  0, 1, 8'hFF};
        tbl[4] = '{1'b0, 1'b0, 3'd0, 8'h12, 20,  0, 0, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 3'd0, 8'h00, 20,  0, 1, 8'hC0};
        tbl[6] = '{1'b1, 1'b0, 3'd3, 8'h5A, 200, 1, 0, 8'h00};
        tbl[7] = '{1'b0, 1'b1, 3'd3, 8'h00, 20,  0, 0, 8'h00};
        tbl[8] = '{1'b1, 1'b1, 3'd3, 8'h00, 20,  0, 1, 8'h5A};
        tbl[9] = '{1'b1, 1'b1, 3'd6, 8'h00, 20,  0, 1, 8'h40};

        drive(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_dout", bus_a.dout, 8'h00);
        chk("rst_oe", bus_a.dout_oe, 1'b0);
        chk("rst_irq", bus_a.irq_n_pin, 1'b1);
        chk("rst_abort", abort_a, 8'h00);
        chk("rst_we_n", we_n_a, 1'b1);
        chk("rst_tmr_a", ta_a, 3'b001);
        chk("rst_tmr_di", tdi_a, 8'h00);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // write: single strobe at fixed latency, bus never driven
        wq.push_back({3'd6, 8'h40});
        drive(1'b1, 1'b1, 1'b0, 3'd6, 8'h40);
        n = 0; kf = 0; oe_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!we_n_a) begin
                n++;
                if (kf == 0) kf = k;
            end
            oe_seen |= bus_a.dout_oe;
        end
        phi2_set(1'b0);
        chk("wr_count", n, 1);
        chk("wr_latency", kf, LAT_WR);
        chk("wr_no_oe", oe_seen, 1'b0);
        repeat (8) @(negedge clk);

        // read: data and oe timing
        rq.push_back(8'h3F);
        w0 = wr_cnt;
        drive(1'b1, 1'b1, 1'b1, 3'd4, 8'h00);
        kf = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus_a.dout_oe && kf == 0) kf = k;
        end
        chk("rd_latency", kf, LAT_RD);
        phi2_set(1'b0);
        repeat (2) @(negedge clk);
        chk("rd_oe_hold", bus_a.dout_oe, 1'b1);
        @(negedge clk);
        chk("rd_oe_drop", bus_a.dout_oe, 1'b0);
        chk("rd_dout_keep", bus_a.dout, 8'h3F);
        chk("rd_no_we", wr_cnt - w0, 0);
        repeat (6) @(negedge clk);

        foreach (tbl[i]) begin
            w0 = wr_cnt;
            r0 = rd_cnt;
            if (tbl[i].exp_wr != 0) wq.push_back({tbl[i].addr, tbl[i].din});
            if (tbl[i].exp_rd != 0) rq.push_back(tbl[i].exp_do);
            bus_cycle(tbl[i].cs, tbl[i].rw, tbl[i].addr, tbl[i].din,
                      tbl[i].hi, 8);
            chk($sformatf("tbl%0d_wr", i), wr_cnt - w0, tbl[i].exp_wr);
            chk($sformatf("tbl%0d_rd", i), rd_cnt - r0, tbl[i].exp_rd);
        end

        // irq follows the timer one clk later, mid bus cycle
        rq.push_back(8'h3F);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 3'd4, 8'h00);
        repeat (10) @(negedge clk);
        tmr_irq_n = 1'b0;
        #1 chk("irq_not_yet", bus_a.irq_n_pin, 1'b1);
        @(posedge clk); #1;
        chk("irq_assert", bus_a.irq_n_pin, 1'b0);
        @(negedge clk);
        tmr_irq_n = 1'b1;
        @(posedge clk); #1;
        chk("irq_release", bus_a.irq_n_pin, 1'b1);
        @(negedge clk);
        phi2_set(1'b0);
        repeat (8) @(negedge clk);

        // reset in SETUP, phi2 held high across release
        w0 = wr_cnt;
        drive(1'b1, 1'b1, 1'b0, 3'd5, 8'h77);
        repeat (3) @(negedge clk);
        chk("setup_tmr_a", ta_a, 3'd5);
        rst_n = 1'b0;
        #1;
        chk("mrst_we_n", we_n_a, 1'b1);
        chk("mrst_oe", bus_a.dout_oe, 1'b0);
        chk("mrst_tmr_a", ta_a, 3'b001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mrst_no_access", wr_cnt - w0, 0);
        phi2_set(1'b0);
        repeat (8) @(negedge clk);
        wq.push_back({3'd5, 8'h77});
        bus_cycle(1'b1, 1'b0, 3'd5, 8'h77, 20, 8);
        chk("mrst_next_wr", wr_cnt - w0, 1);

        // short phi2 aborts only the slow-settle instance
        rq.push_back(8'h3F);
        bus_cycle(1'b1, 1'b1, 3'd4, 8'h00, 3, 6);
        chk("abort_one", abort_b, 8'h01);
        chk("abort_a_none", abort_a, 8'h00);
        for (int i = 0; i < 299; i++) begin
            rq.push_back(8'h3F);
            bus_cycle(1'b1, 1'b1, 3'd4, 8'h00, 3, 6);
        end
        chk("abort_sat", abort_b, 8'hFF);
        chk("abort_a_still", abort_a, 8'h00);

        repeat (4) @(negedge clk);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
